// File: rtl/stack_mem_pkg.sv
// Shared constants, command encodings and FSM states for the stack/memory controller.
package stack_mem_pkg;
    localparam int ADDR_W      = 5;
    localparam int DATA_W      = 8;
    localparam int STACK_TOP   = 31;
    localparam int STACK_LIMIT = 16;
    localparam int DEPTH       = STACK_TOP - STACK_LIMIT + 1;
    localparam int CNT_W       = ADDR_W + 1;

    typedef enum logic [1:0] {
        OP_PUSH  = 2'd0,
        OP_POP   = 2'd1,
        OP_LOAD  = 2'd2,
        OP_STORE = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_e;
endpackage

// File: rtl/stack_mem_ctrl_if.sv
// Command/response, stack status and data-memory port bundle of stack_mem_ctrl.
interface stack_mem_ctrl_if;
    import stack_mem_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_data;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;
    logic [CNT_W-1:0]  count;
    logic              empty;
    logic              full;
    logic [ADDR_W-1:0] mem_a;
    logic [DATA_W-1:0] mem_wd;
    logic              mem_write;
    logic [DATA_W-1:0] mem_rd;

    // Controller side.
    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_data, mem_rd,
        output cmd_ready, rsp_valid, rsp_data, rsp_err, count, empty, full,
               mem_a, mem_wd, mem_write
    );

    // Requester plus memory side.
    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_data, mem_rd,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err, count, empty, full,
               mem_a, mem_wd, mem_write
    );
endinterface

// File: rtl/stack_mem_ctrl.sv
// One-command-at-a-time PUSH/POP/LOAD/STORE initiator for a 32x8 async-read memory.
// Accept -> memory access next cycle -> one-cycle response pulse; no response backpressure.
module stack_mem_ctrl
    import stack_mem_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    stack_mem_ctrl_if.slave  bus
);

    state_e            r_state, w_next;
    op_e               r_op;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic              r_err;
    logic [CNT_W-1:0]  r_count;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_rsp_err;

    logic              w_accept;
    logic              w_empty;
    logic              w_full;
    logic              w_err_new;
    logic              w_is_write;
    logic              w_is_read;
    logic [ADDR_W-1:0] w_mem_a;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == CNT_W'(DEPTH));
    assign w_accept   = bus.cmd_valid && (r_state == S_IDLE);
    assign w_err_new  = ((bus.cmd_op == OP_PUSH) && w_full) ||
                        ((bus.cmd_op == OP_POP)  && w_empty);
    assign w_is_write = (r_op == OP_PUSH) || (r_op == OP_STORE);
    assign w_is_read  = (r_op == OP_POP)  || (r_op == OP_LOAD);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_next = S_ACCESS;
            S_ACCESS: w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Stack addresses are formed one bit wider than the port and truncated.
    always_comb begin
        w_mem_a = r_addr;
        if (r_state == S_ACCESS) begin
            case (r_op)
                OP_PUSH: w_mem_a = ADDR_W'(CNT_W'(STACK_TOP) - r_count);
                OP_POP:  w_mem_a = ADDR_W'(CNT_W'(STACK_TOP) - r_count + CNT_W'(1));
                default: w_mem_a = r_addr;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_op       <= OP_PUSH;
            r_addr     <= '0;
            r_data     <= '0;
            r_err      <= 1'b0;
            r_count    <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_op   <= op_e'(bus.cmd_op);
                r_addr <= bus.cmd_addr;
                r_data <= bus.cmd_data;
                r_err  <= w_err_new;
            end
            if (r_state == S_ACCESS) begin
                r_rsp_data <= (w_is_read && !r_err) ? bus.mem_rd : '0;
                r_rsp_err  <= r_err;
                if (!r_err) begin
                    if (r_op == OP_PUSH)     r_count <= r_count + CNT_W'(1);
                    else if (r_op == OP_POP) r_count <= r_count - CNT_W'(1);
                end
            end
        end
    end

    assign bus.cmd_ready = (r_state == S_IDLE);
    assign bus.rsp_valid = (r_state == S_DONE);
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.count     = r_count;
    assign bus.empty     = w_empty;
    assign bus.full      = w_full;
    assign bus.mem_a     = w_mem_a;
    assign bus.mem_wd    = r_data;
    // Reset must suppress a write even when it lands in the middle of an access.
    assign bus.mem_write = (r_state == S_ACCESS) && w_is_write && !r_err && !rst;

endmodule

// File: tb/tb_stack_mem_ctrl.sv
// Directed plus random bench for stack_mem_ctrl with a behavioural stack/memory model.
module tb_stack_mem_ctrl;
    import stack_mem_pkg::*;

    bit   clk = 1'b0;
    logic rst;

    stack_mem_ctrl_if bus ();

    stack_mem_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Environment memory: write on posedge, combinational read.
    logic [DATA_W-1:0] mem [32];
    always @(posedge clk) if (bus.mem_write === 1'b1) mem[bus.mem_a] <= bus.mem_wd;
    assign bus.mem_rd = mem[bus.mem_a];

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] ref_mem [32];
    int                ref_count = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        ref_count = 0;
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [4:0] addr,
                          input logic [7:0] data, input bit rst_mid);
        bit          exp_err;
        bit          exp_we;
        logic [4:0]  exp_a;
        logic [7:0]  exp_rd;
        int          n;
        exp_err = (op == 2'd0 && ref_count == DEPTH) || (op == 2'd1 && ref_count == 0);
        exp_we  = (op == 2'd0 || op == 2'd3) && !exp_err;
        case (op)
            2'd0:    exp_a = 5'(STACK_TOP - ref_count);
            2'd1:    exp_a = 5'(STACK_TOP - ref_count + 1);
            default: exp_a = addr;
        endcase
        exp_rd = ((op == 2'd1 || op == 2'd2) && !exp_err) ? ref_mem[exp_a] : 8'h00;

        @(negedge clk);
        n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("idle_ready", {31'd0, bus.cmd_ready}, 32'd1);
        check("idle_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_addr  = addr;
        bus.cmd_data  = data;
        @(negedge clk);
        bus.cmd_valid = 1'b0;

        // Access cycle.
        check("acc_ready", {31'd0, bus.cmd_ready}, 32'd0);
        check("acc_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("acc_we", {31'd0, bus.mem_write}, {31'd0, exp_we});
        if (!exp_err) check("acc_addr", {27'd0, bus.mem_a}, {27'd0, exp_a});
        if (exp_we)   check("acc_wd", {24'd0, bus.mem_wd}, {24'd0, data});

        if (rst_mid) begin
            rst = 1'b1;
            #1;
            check("rst_we_gated", {31'd0, bus.mem_write}, 32'd0);
            @(negedge clk);
            ref_count = 0;
            check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
            check("rst_count", {26'd0, bus.count}, 32'd0);
            check("rst_ready", {31'd0, bus.cmd_ready}, 32'd1);
            rst = 1'b0;
            return;
        end

        if (exp_we) ref_mem[exp_a] = data;
        if (!exp_err && op == 2'd0) ref_count++;
        if (!exp_err && op == 2'd1) ref_count--;

        // Response cycle.
        @(negedge clk);
        check("rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
        check("rsp_data", {24'd0, bus.rsp_data}, {24'd0, exp_rd});
        check("rsp_err", {31'd0, bus.rsp_err}, {31'd0, exp_err});
        check("count", {26'd0, bus.count}, 32'(ref_count));
        check("empty", {31'd0, bus.empty}, {31'd0, (ref_count == 0)});
        check("full", {31'd0, bus.full}, {31'd0, (ref_count == DEPTH)});
        if (exp_we) check("mem_written", {24'd0, mem[exp_a]}, {24'd0, data});
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'd0;
        bus.cmd_addr  = '0;
        bus.cmd_data  = '0;
        do_reset();

        check("reset_ready", {31'd0, bus.cmd_ready}, 32'd1);
        check("reset_count", {26'd0, bus.count}, 32'd0);
        check("reset_empty", {31'd0, bus.empty}, 32'd1);
        check("reset_full", {31'd0, bus.full}, 32'd0);
        check("reset_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("reset_rsp_data", {24'd0, bus.rsp_data}, 32'd0);
        check("reset_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
        check("reset_we", {31'd0, bus.mem_write}, 32'd0);

        // Single push lands at the top of the stack.
        do_cmd(2'd0, 5'd0, 8'hA5, 1'b0);
        check("t1_mem31", {24'd0, mem[31]}, 32'hA5);

        // LIFO order.
        do_reset();
        do_cmd(2'd0, 5'd0, 8'hA5, 1'b0);
        do_cmd(2'd0, 5'd0, 8'h3C, 1'b0);
        do_cmd(2'd1, 5'd0, 8'h00, 1'b0);
        do_cmd(2'd1, 5'd0, 8'h00, 1'b0);

        // Underflow.
        do_cmd(2'd1, 5'd0, 8'h00, 1'b0);

        // Fill every location with known random data.
        for (int i = 0; i < 32; i++) do_cmd(2'd3, 5'(i), 8'($urandom), 1'b0);

        // Fill the stack, then overflow.
        for (int i = 0; i < 16; i++) do_cmd(2'd0, 5'd0, 8'(i), 1'b0);
        check("t4_full", {31'd0, bus.full}, 32'd1);
        do_cmd(2'd0, 5'd0, 8'hFF, 1'b0);
        check("t4_mem15", {24'd0, mem[15]}, {24'd0, ref_mem[15]});

        // STORE/LOAD round trip leaves count alone.
        do_cmd(2'd3, 5'd5, 8'h7E, 1'b0);
        do_cmd(2'd2, 5'd5, 8'h00, 1'b0);

        // Reset in the middle of a push access.
        for (int i = 0; i < 13; i++) do_cmd(2'd1, 5'd0, 8'h00, 1'b0);
        check("t6_count3", {26'd0, bus.count}, 32'd3);
        do_cmd(2'd0, 5'd0, 8'h55, 1'b1);
        check("t6_mem28", {24'd0, mem[28]}, {24'd0, ref_mem[28]});

        // Random mix, stack ops weighted to reach both full and empty.
        for (int i = 0; i < 120; i++) begin
            int r;
            logic [1:0] op;
            r = int'($urandom_range(0, 9));
            op = (r < 4) ? 2'd0 : (r < 8) ? 2'd1 : (r == 8) ? 2'd2 : 2'd3;
            do_cmd(op, 5'($urandom_range(0, 31)), 8'($urandom), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "simulation time limit reached");
    end

endmodule
